// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch prefetch queue.
// Holds the FSM encoding, the FIFO entry layout and the address alignment helper.
package fetch_pkg;

  localparam int INSTR_W       = 32;
  localparam int ADDR_W        = 32;
  localparam int DEFAULT_DEPTH = 4;

  typedef enum logic [1:0] {
    FQ_IDLE = 2'd0,
    FQ_REQ  = 2'd1,
    FQ_WAIT = 2'd2
  } fq_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of {pc, instr} entries with flush; head is read straight from storage.
// Flush wins over push and pop in the same cycle.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  fetch_entry_t             wdata,
  output fetch_entry_t             rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_C);
  assign do_push = push && !flush && !full;
  assign do_pop  = pop && !flush && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately left out of reset; the head is only observed
  // while count is non-zero, so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/fetch_prefetch_queue.sv
// Fetch front end: sequential word fetches over req/gnt/rvalid, buffered with their PCs,
// head presented to the core; a redirect flushes the buffer and kills the in-flight response.
module fetch_prefetch_queue
  import fetch_pkg::*;
#(
  parameter int                DEPTH    = DEFAULT_DEPTH,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               reset,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_gnt,
  input  logic               mem_rvalid,
  input  logic [INSTR_W-1:0] mem_rdata,
  input  logic               instr_ready,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  fq_state_t         state;
  fq_state_t         state_next;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] fetch_pc_next;
  logic [ADDR_W-1:0] req_pc;
  logic [ADDR_W-1:0] req_pc_next;
  logic [ADDR_W-1:0] redirect_word;
  logic              kill;
  logic              kill_next;
  logic              push;
  logic              pop;
  logic              empty;
  logic              full;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_after;
  fetch_entry_t      push_entry;
  fetch_entry_t      head;

  assign redirect_word = word_align(redirect_pc);
  assign push          = (state == FQ_WAIT) && mem_rvalid && !kill && !redirect;
  assign pop           = instr_ready && !empty;
  assign count_after   = redirect ? '0 : count + CNT_W'(push) - CNT_W'(pop);
  assign push_entry    = '{pc: req_pc, instr: mem_rdata};

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .wdata (push_entry),
    .rdata (head),
    .count (count),
    .empty (empty),
    .full  (full)
  );

  // NOTE: every signal written here gets its default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    state_next    = state;
    fetch_pc_next = fetch_pc;
    kill_next     = kill;
    req_pc_next   = req_pc;
    case (state)
      FQ_IDLE: begin
        if (redirect) begin
          fetch_pc_next = redirect_word;
          state_next    = FQ_REQ;
        end else if (!full) begin
          state_next = FQ_REQ;
        end
      end
      FQ_REQ: begin
        // A killed request leaves fetch_pc at the redirect target when granted.
        if (mem_gnt) begin
          state_next = FQ_WAIT;
          if (!kill) fetch_pc_next = fetch_pc + 32'd4;
        end
        if (redirect) begin
          fetch_pc_next = redirect_word;
          kill_next     = 1'b1;
        end
      end
      FQ_WAIT: begin
        if (mem_rvalid) begin
          kill_next  = 1'b0;
          state_next = (count_after < DEPTH_C) ? FQ_REQ : FQ_IDLE;
        end else if (redirect) begin
          kill_next = 1'b1;
        end
        if (redirect) fetch_pc_next = redirect_word;
      end
      default: state_next = FQ_IDLE;
    endcase
    // The request address is frozen on entry to REQ so a redirect cannot disturb it.
    if (state_next == FQ_REQ && state != FQ_REQ) req_pc_next = fetch_pc_next;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= FQ_IDLE;
      fetch_pc <= RESET_PC;
      req_pc   <= RESET_PC;
      kill     <= 1'b0;
    end else begin
      state    <= state_next;
      fetch_pc <= fetch_pc_next;
      req_pc   <= req_pc_next;
      kill     <= kill_next;
    end
  end

  assign mem_req     = (state == FQ_REQ);
  assign mem_addr    = (state == FQ_REQ) ? req_pc : fetch_pc;
  assign instr_valid = !empty;
  assign instr       = empty ? '0 : head.instr;
  assign instr_pc    = empty ? '0 : head.pc;

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Directed bench for fetch_prefetch_queue: a vector table for the zero-wait stream,
// then hand-written sequences for stall, redirect and reset corner cases.
module tb_fetch_prefetch_queue;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        instr_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  always #5 clk = ~clk;

  fetch_prefetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .reset       (reset),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_gnt     (mem_gnt),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata),
    .instr_ready (instr_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc)
  );

  typedef struct {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        ready;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_instr;
    logic [31:0] exp_pc;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] grants[$];
  logic [31:0] popped_pc[$];
  logic [31:0] popped_instr[$];
  logic        pend = 1'b0;
  logic [31:0] pend_addr = '0;
  vec_t        vecs[7];

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return 32'hC0DE_0000 ^ a;
  endfunction

  function automatic logic [31:0] pick(input logic [31:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 32'hDEAD_BEEF;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic g, input logic rv, input logic [31:0] rd,
                       input logic rdy, input logic redir, input logic [31:0] rpc);
    mem_gnt     = g;
    mem_rvalid  = rv;
    mem_rdata   = rd;
    instr_ready = rdy;
    redirect    = redir;
    redirect_pc = rpc;
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_logs;
    grants.delete();
    popped_pc.delete();
    popped_instr.delete();
  endtask

  task automatic do_reset;
    reset = 1'b0;
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
    tick();
    check("rst_req", {31'd0, mem_req}, 32'd0);
    check("rst_addr", mem_addr, 32'h0);
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_instr", instr, 32'h0);
    check("rst_pc", instr_pc, 32'h0);
    reset = 1'b1;
    pend  = 1'b0;
    clear_logs();
  endtask

  // Zero-wait memory: grant any request at once, answer it on the following cycle.
  task automatic zw_cycle(input logic rdy);
    logic        g;
    logic        rv;
    logic [31:0] rd;
    g  = 1'b0;
    rv = 1'b0;
    rd = '0;
    if (instr_valid && rdy) begin
      popped_pc.push_back(instr_pc);
      popped_instr.push_back(instr);
    end
    if (mem_req) begin
      g         = 1'b1;
      pend      = 1'b1;
      pend_addr = mem_addr;
      grants.push_back(mem_addr);
    end else if (pend) begin
      rv   = 1'b1;
      rd   = word_of(pend_addr);
      pend = 1'b0;
    end
    drive(g, rv, rd, rdy, 1'b0, '0);
    tick();
  endtask

  task automatic run_until_grants(input int n, input logic rdy);
    for (int i = 0; i < 40 && grants.size() < n; i++) zw_cycle(rdy);
  endtask

  initial begin
    int n_stale;

    vecs[0] = '{1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0, 1'b0, 32'h0,        32'h0};
    vecs[1] = '{1'b0, 1'b1, word_of(0),   1'b1, 1'b0, 32'h0, 1'b0, 32'h0,        32'h0};
    vecs[2] = '{1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'h4, 1'b1, word_of(0),   32'h0};
    vecs[3] = '{1'b0, 1'b1, word_of(4),   1'b1, 1'b0, 32'h0, 1'b0, 32'h0,        32'h0};
    vecs[4] = '{1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 32'h8, 1'b1, word_of(4),   32'h4};
    vecs[5] = '{1'b0, 1'b1, word_of(8),   1'b1, 1'b0, 32'h0, 1'b0, 32'h0,        32'h0};
    vecs[6] = '{1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 32'hC, 1'b1, word_of(8),   32'h8};

    @(negedge clk);

    // 1: zero-wait stream, outputs checked before each vector's inputs are applied
    do_reset();
    drive(1'b0, 1'b0, '0, 1'b1, 1'b0, '0);
    tick();
    for (int i = 0; i < 7; i++) begin
      check($sformatf("t1_req_%0d", i), {31'd0, mem_req}, {31'd0, vecs[i].exp_req});
      if (vecs[i].exp_req) check($sformatf("t1_addr_%0d", i), mem_addr, vecs[i].exp_addr);
      check($sformatf("t1_valid_%0d", i), {31'd0, instr_valid}, {31'd0, vecs[i].exp_valid});
      check($sformatf("t1_instr_%0d", i), instr, vecs[i].exp_instr);
      check($sformatf("t1_pc_%0d", i), instr_pc, vecs[i].exp_pc);
      drive(vecs[i].gnt, vecs[i].rvalid, vecs[i].rdata, vecs[i].ready, 1'b0, '0);
      tick();
    end

    // 2: core stalled, buffer fills to DEPTH, then drains in order
    do_reset();
    for (int i = 0; i < 14; i++) zw_cycle(1'b0);
    check("t2_grants", grants.size(), 32'd4);
    check("t2_req_idle", {31'd0, mem_req}, 32'd0);
    check("t2_valid", {31'd0, instr_valid}, 32'd1);
    check("t2_head_pc", instr_pc, 32'h0);
    check("t2_head_instr", instr, word_of(0));
    clear_logs();
    for (int i = 0; i < 12; i++) zw_cycle(1'b1);
    check("t2_drain0", pick(popped_pc, 0), 32'h0);
    check("t2_drain1", pick(popped_pc, 1), 32'h4);
    check("t2_drain2", pick(popped_pc, 2), 32'h8);
    check("t2_drain3", pick(popped_pc, 3), 32'hC);
    check("t2_drain3_instr", pick(popped_instr, 3), word_of(32'hC));
    check("t2_resume", pick(grants, 0), 32'h10);

    // 3: redirect while waiting on the response for address 8
    do_reset();
    run_until_grants(3, 1'b1);
    check("t3_reach", grants.size(), 32'd3);
    clear_logs();
    drive(1'b0, 1'b0, '0, 1'b1, 1'b1, 32'h100);
    tick();
    check("t3_hold_wait", {31'd0, mem_req}, 32'd0);
    for (int i = 0; i < 10; i++) zw_cycle(1'b1);
    check("t3_next_addr", pick(grants, 0), 32'h100);
    check("t3_first_pc", pick(popped_pc, 0), 32'h100);
    check("t3_first_instr", pick(popped_instr, 0), word_of(32'h100));
    n_stale = 0;
    foreach (popped_pc[i]) if (popped_pc[i] == 32'h8) n_stale++;
    check("t3_no_stale", n_stale, 32'd0);

    // 4: redirect while the request is stalled without grant
    do_reset();
    drive(1'b0, 1'b0, '0, 1'b1, 1'b0, '0);
    tick();
    check("t4_req", {31'd0, mem_req}, 32'd1);
    drive(1'b0, 1'b0, '0, 1'b1, 1'b1, 32'h202);
    tick();
    check("t4_hold_a", mem_addr, 32'h0);
    drive(1'b0, 1'b0, '0, 1'b1, 1'b0, '0);
    tick();
    check("t4_hold_b", mem_addr, 32'h0);
    tick();
    check("t4_hold_c", {mem_addr[31:1], mem_req}, 32'h1);
    drive(1'b1, 1'b0, '0, 1'b1, 1'b0, '0);
    tick();
    drive(1'b0, 1'b1, word_of(0), 1'b1, 1'b0, '0);
    tick();
    check("t4_dropped", {31'd0, instr_valid}, 32'd0);
    check("t4_new_req", {31'd0, mem_req}, 32'd1);
    check("t4_new_addr", mem_addr, 32'h200);
    clear_logs();
    for (int i = 0; i < 8; i++) zw_cycle(1'b1);
    check("t4_first_pc", pick(popped_pc, 0), 32'h200);
    check("t4_first_instr", pick(popped_instr, 0), word_of(32'h200));

    // 5: redirect together with rvalid and a pop
    do_reset();
    run_until_grants(2, 1'b0);
    check("t5_reach", grants.size(), 32'd2);
    check("t5_head", instr_pc, 32'h0);
    drive(1'b0, 1'b1, word_of(4), 1'b1, 1'b1, 32'h300);
    tick();
    pend = 1'b0;
    check("t5_flushed", {31'd0, instr_valid}, 32'd0);
    check("t5_req", {31'd0, mem_req}, 32'd1);
    check("t5_addr", mem_addr, 32'h300);
    clear_logs();
    for (int i = 0; i < 8; i++) zw_cycle(1'b1);
    check("t5_first_pc", pick(popped_pc, 0), 32'h300);
    check("t5_first_instr", pick(popped_instr, 0), word_of(32'h300));

    // 6: reset in the middle of WAIT, stale response afterwards
    do_reset();
    run_until_grants(2, 1'b1);
    check("t6_reach", grants.size(), 32'd2);
    reset = 1'b0;
    drive(1'b0, 1'b0, '0, 1'b1, 1'b0, '0);
    tick();
    check("t6_rst_req", {31'd0, mem_req}, 32'd0);
    check("t6_rst_addr", mem_addr, 32'h0);
    reset = 1'b1;
    drive(1'b0, 1'b1, word_of(4), 1'b1, 1'b0, '0);
    tick();
    check("t6_req", {31'd0, mem_req}, 32'd1);
    check("t6_addr", mem_addr, 32'h0);
    check("t6_valid_a", {31'd0, instr_valid}, 32'd0);
    drive(1'b0, 1'b1, word_of(4), 1'b1, 1'b0, '0);
    tick();
    check("t6_valid_b", {31'd0, instr_valid}, 32'd0);
    pend = 1'b0;
    clear_logs();
    for (int i = 0; i < 6; i++) zw_cycle(1'b1);
    check("t6_grant", pick(grants, 0), 32'h0);
    check("t6_first_pc", pick(popped_pc, 0), 32'h0);
    check("t6_first_instr", pick(popped_instr, 0), word_of(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
